// File: rtl/types_pkg.sv
// Shared types and defaults for the data-memory port arbiter.
// Holds the FSM state encoding and the ROB age helper used by the age comparator.
package types_pkg;

    localparam int STARVE_LIMIT_DEF = 4;
    localparam int MEM_TIMEOUT_DEF  = 15;
    localparam int ROB_W            = 5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LD_WAIT = 2'd1,
        DROP    = 2'd2
    } mem_arb_state_t;

    // Distance from the ROB head; wraps naturally in 5-bit arithmetic.
    function automatic logic [ROB_W-1:0] rob_age(input logic [ROB_W-1:0] head,
                                                 input logic [ROB_W-1:0] tag);
        return tag - head;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rob_age_cmp.sv
// ROB age comparator: flags when tag a is younger than tag b
// relative to the current ROB head.
module rob_age_cmp
    import types_pkg::*;
(
    input  logic [ROB_W-1:0] head,
    input  logic [ROB_W-1:0] a,
    input  logic [ROB_W-1:0] b,
    output logic             a_younger
);

    assign a_younger = rob_age(head, a) > rob_age(head, b);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one data-memory port between LSQ loads and retired-store writeback,
// tracking a single outstanding load with flush and timeout handling.
//
// state   | meaning
// IDLE    | port free; grant a store or a load this cycle
// LD_WAIT | load issued, waiting for mem_rvalid
// DROP    | load flushed, swallow its late response
module mem_port_arbiter
    import types_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
    parameter int MEM_TIMEOUT  = MEM_TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [31:0] ld_addr,
    input  logic [6:0]  ld_pd,
    input  logic [4:0]  ld_rob,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    input  logic [4:0]  rob_head,
    input  logic        mispredict,
    input  logic [4:0]  mispredict_tag,
    output logic        ld_done,
    output logic [6:0]  ld_done_pd,
    output logic [4:0]  ld_done_rob,
    output logic [31:0] ld_done_data,
    output logic        busy,
    output logic        ld_timeout
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int WW = $clog2(MEM_TIMEOUT + 1);

    mem_arb_state_t state, state_nxt;
    logic [SW-1:0]  starve_cnt, starve_nxt;
    logic [WW-1:0]  wait_cnt, wait_nxt;
    logic [6:0]     pd_q, pd_nxt;
    logic [4:0]     rob_q, rob_nxt;
    logic           req_younger, held_younger;
    logic           kill_req, kill_held, starved, timed_out;

    rob_age_cmp u_cmp_req (
        .head      (rob_head),
        .a         (ld_rob),
        .b         (mispredict_tag),
        .a_younger (req_younger)
    );

    rob_age_cmp u_cmp_held (
        .head      (rob_head),
        .a         (rob_q),
        .b         (mispredict_tag),
        .a_younger (held_younger)
    );

    assign kill_req  = mispredict & req_younger;
    assign kill_held = mispredict & held_younger;
    assign starved   = (starve_cnt == SW'(STARVE_LIMIT));
    assign timed_out = (wait_cnt == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            starve_cnt <= '0;
            wait_cnt   <= '0;
            pd_q       <= '0;
            rob_q      <= '0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
            wait_cnt   <= wait_nxt;
            pd_q       <= pd_nxt;
            rob_q      <= rob_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        starve_nxt   = starve_cnt;
        wait_nxt     = wait_cnt;
        pd_nxt       = pd_q;
        rob_nxt      = rob_q;
        ld_ready     = 1'b0;
        st_ready     = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        ld_done      = 1'b0;
        ld_done_pd   = '0;
        ld_done_rob  = '0;
        ld_done_data = '0;
        ld_timeout   = 1'b0;
        busy         = (state != IDLE);

        unique case (state)
            IDLE: begin
                // Readies look only at the other requester's valid, so a starved
                // load holds the port even for the cycle its valid drops.
                ld_ready = !kill_req && (!st_valid || starved);
                st_ready = !ld_ready;
                if (ld_valid && ld_ready) begin
                    mem_req   = 1'b1;
                    mem_addr  = ld_addr;
                    pd_nxt    = ld_pd;
                    rob_nxt   = ld_rob;
                    wait_nxt  = WW'(MEM_TIMEOUT - 1);
                    state_nxt = LD_WAIT;
                end else if (st_valid && st_ready) begin
                    mem_req   = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = st_addr;
                    mem_wdata = st_data;
                end
            end
            LD_WAIT: begin
                if (!timed_out) wait_nxt = wait_cnt - 1'b1;
                if (mem_rvalid) begin
                    ld_done   = !kill_held;
                    state_nxt = IDLE;
                end else if (timed_out) begin
                    ld_timeout = !kill_held;
                    state_nxt  = IDLE;
                end else if (kill_held) begin
                    state_nxt = DROP;
                end
                if (ld_done) begin
                    ld_done_pd   = pd_q;
                    ld_done_rob  = rob_q;
                    ld_done_data = mem_rdata;
                end
            end
            DROP: begin
                if (!timed_out) wait_nxt = wait_cnt - 1'b1;
                if (mem_rvalid || timed_out) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        if (!ld_valid || ld_ready) begin
            starve_nxt = '0;
        end else if (st_valid && st_ready && !starved) begin
            starve_nxt = starve_cnt + 1'b1;
        end

        if (reset) begin
            ld_ready     = 1'b0;
            st_ready     = 1'b0;
            mem_req      = 1'b0;
            mem_we       = 1'b0;
            mem_addr     = '0;
            mem_wdata    = '0;
            ld_done      = 1'b0;
            ld_done_pd   = '0;
            ld_done_rob  = '0;
            ld_done_data = '0;
            ld_timeout   = 1'b0;
            busy         = 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; load completions are checked against a
// scoreboard queue filled when the memory response is driven.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        ld_valid, ld_ready;
    logic [31:0] ld_addr;
    logic [6:0]  ld_pd;
    logic [4:0]  ld_rob;
    logic        st_valid, st_ready;
    logic [31:0] st_addr, st_data;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [4:0]  rob_head;
    logic        mispredict;
    logic [4:0]  mispredict_tag;
    logic        ld_done;
    logic [6:0]  ld_done_pd;
    logic [4:0]  ld_done_rob;
    logic [31:0] ld_done_data;
    logic        busy, ld_timeout;

    int n_cmp = 0;
    int n_err = 0;
    logic [43:0] sb[$];

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk(clk), .reset(reset),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_pd(ld_pd), .ld_rob(ld_rob),
        .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .rob_head(rob_head), .mispredict(mispredict), .mispredict_tag(mispredict_tag),
        .ld_done(ld_done), .ld_done_pd(ld_done_pd), .ld_done_rob(ld_done_rob),
        .ld_done_data(ld_done_data), .busy(busy), .ld_timeout(ld_timeout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_load(input logic [31:0] a, input logic [6:0] pd, input logic [4:0] rob);
        ld_valid = 1'b1; ld_addr = a; ld_pd = pd; ld_rob = rob;
        #1;
        chk("load_grant_ready", ld_ready, 1);
        chk("load_grant_addr", mem_addr, a);
        next();
        ld_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!reset && ld_done === 1'b1) begin
            n_cmp++;
            assert (sb.size() != 0) else begin
                n_err++;
                $error("FAIL unexpected_ld_done: observed pd %0d rob %0d data %0h expected none",
                       ld_done_pd, ld_done_rob, ld_done_data);
            end
            if (sb.size() != 0) chk("ld_done_payload", 32'({ld_done_pd, ld_done_rob, ld_done_data} ^ sb[0]), 0);
            if (sb.size() != 0) void'(sb.pop_front());
        end
    end

    initial begin
        reset = 1'b1;
        ld_valid = 1'b1; ld_addr = 32'h40; ld_pd = 7'd1; ld_rob = 5'd1;
        st_valid = 1'b1; st_addr = 32'h80; st_data = 32'h1;
        mem_rvalid = 1'b0; mem_rdata = '0;
        rob_head = '0; mispredict = 1'b0; mispredict_tag = '0;
        repeat (2) next();
        chk("rst_ld_ready", ld_ready, 0);
        chk("rst_st_ready", st_ready, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", mem_addr, 0);
        ld_valid = 1'b0; st_valid = 1'b0;
        reset = 1'b0;
        next();
        chk("idle_ld_ready", ld_ready, 1);
        chk("idle_st_ready", st_ready, 0);
        chk("idle_busy", busy, 0);

        // plain load, response two cycles after grant
        issue_load(32'h100, 7'd12, 5'd3);
        #1;
        chk("ld1_busy_c1", busy, 1);
        chk("ld1_ready_c1", ld_ready, 0);
        chk("st1_ready_c1", st_ready, 0);
        next();
        mem_rvalid = 1'b1; mem_rdata = 32'hDEAD;
        sb.push_back({7'd12, 5'd3, 32'hDEAD});
        #1;
        chk("ld1_done", ld_done, 1);
        chk("ld1_busy_c2", busy, 1);
        next();
        mem_rvalid = 1'b0;
        #1;
        chk("ld1_busy_after", busy, 0);

        // single store
        st_valid = 1'b1; st_addr = 32'h200; st_data = 32'h55AA;
        #1;
        chk("st_ready", st_ready, 1);
        chk("st_we", mem_we, 1);
        chk("st_wdata", mem_wdata, 32'h55AA);
        chk("st_busy", busy, 0);
        next();

        // stores win until the pending load has been passed over four times
        ld_valid = 1'b1; ld_addr = 32'h300; ld_pd = 7'd5; ld_rob = 5'd4;
        for (int i = 0; i < 4; i++) begin
            st_addr = 32'h400 + i;
            #1;
            chk("starve_st_ready", st_ready, 1);
            chk("starve_ld_ready", ld_ready, 0);
            chk("starve_st_addr", mem_addr, 32'h400 + i);
            next();
        end
        #1;
        chk("starve_ld_wins", ld_ready, 1);
        chk("starve_st_blocked", st_ready, 0);
        chk("starve_ld_we", mem_we, 0);
        chk("starve_ld_addr", mem_addr, 32'h300);
        next();
        ld_valid = 1'b0; st_valid = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h1234;
        sb.push_back({7'd5, 5'd4, 32'h1234});
        next();
        mem_rvalid = 1'b0;

        // flushed load with late response goes through DROP
        rob_head = 5'd30;
        issue_load(32'h500, 7'd9, 5'd1);
        mispredict = 1'b1; mispredict_tag = 5'd31;
        #1;
        chk("kill_no_done", ld_done, 0);
        next();
        mispredict = 1'b0;
        #1;
        chk("drop_busy", busy, 1);
        chk("drop_ld_ready", ld_ready, 0);
        next();
        mem_rvalid = 1'b1; mem_rdata = 32'hBAD;
        #1;
        chk("drop_discard", ld_done, 0);
        next();
        mem_rvalid = 1'b0;
        #1;
        chk("drop_to_idle", busy, 0);

        // older-than-branch load survives a mispredict
        issue_load(32'h600, 7'd7, 5'd31);
        mispredict = 1'b1; mispredict_tag = 5'd1;
        mem_rvalid = 1'b1; mem_rdata = 32'hCAFE;
        sb.push_back({7'd7, 5'd31, 32'hCAFE});
        #1;
        chk("survive_done", ld_done, 1);
        next();
        mispredict = 1'b0; mem_rvalid = 1'b0;

        // kill coinciding with response: straight back to IDLE, no done
        issue_load(32'h700, 7'd8, 5'd1);
        mispredict = 1'b1; mispredict_tag = 5'd31;
        mem_rvalid = 1'b1; mem_rdata = 32'hBEEF;
        #1;
        chk("kill_rvalid_no_done", ld_done, 0);
        next();
        mispredict = 1'b0; mem_rvalid = 1'b0;
        #1;
        chk("kill_rvalid_idle", busy, 0);

        // mispredict in IDLE blocks only a killed load, never a store
        mispredict = 1'b1; mispredict_tag = 5'd31;
        ld_valid = 1'b1; ld_rob = 5'd1; ld_addr = 32'h800;
        #1;
        chk("idle_kill_ld_ready", ld_ready, 0);
        chk("idle_kill_mem_req", mem_req, 0);
        st_valid = 1'b1; st_addr = 32'h900; st_data = 32'h9;
        #1;
        chk("idle_kill_st_ready", st_ready, 1);
        chk("idle_kill_st_addr", mem_addr, 32'h900);
        next();
        mispredict = 1'b0; ld_valid = 1'b0; st_valid = 1'b0;
        rob_head = 5'd0;
        next();

        // timeout after fifteen silent cycles
        issue_load(32'hA00, 7'd3, 5'd2);
        for (int i = 1; i < 15; i++) begin
            #1;
            chk("tmo_wait_busy", busy, 1);
            chk("tmo_no_pulse", ld_timeout, 0);
            next();
        end
        #1;
        chk("tmo_pulse", ld_timeout, 1);
        chk("tmo_no_done", ld_done, 0);
        next();
        #1;
        chk("tmo_idle", busy, 0);
        chk("tmo_pulse_clear", ld_timeout, 0);
        chk("tmo_ld_ready", ld_ready, 1);

        // response while idle is ignored
        mem_rvalid = 1'b1; mem_rdata = 32'h77;
        #1;
        chk("idle_rvalid_ignored", ld_done, 0);
        next();
        mem_rvalid = 1'b0;

        // reset in the middle of a load
        issue_load(32'hB00, 7'd4, 5'd6);
        #1;
        chk("rst_mid_busy_before", busy, 1);
        reset = 1'b1;
        mem_rvalid = 1'b1; mem_rdata = 32'h66;
        #1;
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_done", ld_done, 0);
        chk("rst_mid_ld_ready", ld_ready, 0);
        next();
        reset = 1'b0;
        #1;
        chk("rst_release_no_done", ld_done, 0);
        next();
        mem_rvalid = 1'b0;
        next();

        chk("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
